work_status_tracker: RTL

- Control stage directly upstream of the LED status block.
- Tracks the miner's work lifecycle from the serial-receive strobe and the hashing-core results.
- Produces the single-cycle new_work and new_result pulses and the hashing level that the LED stage consumes.
- Buffers one golden nonce for the serial transmitter using a valid/ready handshake, counts dropped results, and drops stale work after a timeout.

---
 rtl/work_status_tracker.sv | 113 +++++++++++
 1 files changed

// File: rtl/work_status_tracker.sv
// Work lifecycle tracker feeding the LED status stage and the serial transmitter.
// Follows received work through IDLE/HASHING/EXHAUSTED, times out stale work,
// holds one golden nonce behind a valid/ready handshake, and counts lost nonces.
module work_status_tracker #(
  parameter logic [31:0] STALE_CYCLES = 32'd600_000_000,
  parameter int          DROP_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  work_valid,
  input  logic                  nonce_exhausted,
  input  logic                  golden_valid,
  input  logic [31:0]           golden_nonce,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [31:0]           tx_nonce,
  output logic                  new_work,
  output logic                  new_result,
  output logic                  hashing,
  output logic [DROP_WIDTH-1:0] dropped_count,
  output logic [1:0]            state
);

  // state     | meaning
  // IDLE      | no live work; results arriving now are dropped
  // HASHING   | core working on fresh work; stale timer running
  // EXHAUSTED | nonce range done; late results still accepted
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HASHING   = 2'd1;
  localparam logic [1:0] EXHAUSTED = 2'd2;

  logic [1:0]  state_nxt;
  logic [31:0] stale_cnt;
  logic [31:0] stale_nxt;
  logic        accept;
  logic        drop;
  logic        load;

  // Next-state decode; fresh work overrides everything, exhaustion beats stale expiry.
  always_comb begin
    state_nxt = state;
    if (work_valid) begin
      state_nxt = HASHING;
    end else begin
      case (state)
        IDLE:      state_nxt = IDLE;
        HASHING: begin
          if (nonce_exhausted)
            state_nxt = EXHAUSTED;
          else if (stale_cnt == STALE_CYCLES - 32'd1)
            state_nxt = IDLE;
          else
            state_nxt = HASHING;
        end
        EXHAUSTED: state_nxt = EXHAUSTED;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Stale timer counts consecutive HASHING cycles and restarts on every new work.
  always_comb begin
    stale_nxt = 32'd0;
    if (!work_valid && state == HASHING && state_nxt == HASHING)
      stale_nxt = stale_cnt + 32'd1;
  end

  // Result acceptance is judged against the state before any transition this cycle.
  always_comb begin
    accept = golden_valid && (state == HASHING || state == EXHAUSTED);
    load   = accept && (!tx_valid || tx_ready);
    drop   = (golden_valid && !accept) || (accept && !load);
  end

  // FSM, stale timer and the registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      stale_cnt  <= 32'd0;
      new_work   <= 1'b0;
      new_result <= 1'b0;
      hashing    <= 1'b0;
    end else begin
      state      <= state_nxt;
      stale_cnt  <= stale_nxt;
      new_work   <= work_valid;
      new_result <= load;
      hashing    <= (state_nxt == HASHING);
    end
  end

  // Single-entry nonce buffer; a new nonce only replaces the old one when it is being taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_nonce <= 32'd0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_nonce <= golden_nonce;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  // Saturating count of nonces that could not be kept.
  always_ff @(posedge clk) begin
    if (reset)
      dropped_count <= '0;
    else if (drop && (dropped_count != {DROP_WIDTH{1'b1}}))
      dropped_count <= dropped_count + 1'b1;
  end

endmodule
